// File: rtl/motion_pkg.sv
// motion_pkg: shared axis state encoding and at_edge bit positions
package motion_pkg;
  typedef enum logic [1:0] {IDLE, SLOW, FAST} axis_state_t;
  localparam int EDGE_UP = 3;
  localparam int EDGE_DOWN = 2;
  localparam int EDGE_LEFT = 1;
  localparam int EDGE_RIGHT = 0;
endpackage

// File: rtl/motion_controller_axis_stepper.sv
// axis_stepper: one saturating coordinate driven by an inc/dec request pair
// Ports: clock, reset (sync, active-high), tick (advance strobe), inc/dec (level requests),
//        val (registered coordinate), chg (val changes on this edge).
// MOTION_ACCEL_EN adds an IDLE/SLOW/FAST FSM that doubles the step after HOLD_TICKS
// consecutive ticks in one direction; without it the step is always STEP.
module axis_stepper
  import motion_pkg::*;
#(
  parameter int W = 8,
  parameter int MIN = 0,
  parameter int MAX = 2**W-1,
  parameter int RST = 0,
  parameter int STEP = 1,
  parameter int HOLD_TICKS = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tick,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] val,
  output logic         chg
);
  localparam logic [W+1:0] LO = (W+2)'(MIN);
  localparam logic [W+1:0] HI = (W+2)'(MAX);
  localparam logic [W+1:0] S1 = (W+2)'(STEP);
  logic [W-1:0] val_q, val_d;
  logic [W+1:0] stp, up_s, dn_s;
  logic one;
  assign one = inc ^ dec;
`ifdef MOTION_ACCEL_EN
  localparam int HW = $clog2(HOLD_TICKS + 1);
  axis_state_t state_q, state_d;
  logic dir_q, dir_d;
  logic [HW-1:0] hold_q, hold_d;
  // hold counts same-direction ticks after the one that entered SLOW
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    hold_d = hold_q;
    if (tick) begin
      if (!one) begin
        state_d = IDLE;
        hold_d = '0;
      end else if (state_q == IDLE || dir_q != inc) begin
        state_d = SLOW;
        dir_d = inc;
        hold_d = '0;
      end else if (state_q == SLOW) begin
        state_d = hold_q == HW'(HOLD_TICKS - 1) ? FAST : SLOW;
        hold_d = hold_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q <= 1'b0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      hold_q <= hold_d;
    end
  end
  // the step of a tick follows the state that tick enters
  assign stp = state_d == FAST ? S1 << 1 : S1;
`else
  assign stp = S1;
`endif
  // two guard bits keep a doubled step from wrapping before the bound compare
  always_comb begin
    up_s = {2'b00, val_q} + stp;
    dn_s = {2'b00, val_q} - stp;
    val_d = (!tick || !one) ? val_q
          : inc ? (up_s > HI ? HI[W-1:0] : up_s[W-1:0])
          : ({2'b00, val_q} >= LO + stp ? dn_s[W-1:0] : LO[W-1:0]);
  end
  always_ff @(posedge clock) begin
    if (reset) val_q <= W'(RST);
    else val_q <= val_d;
  end
  assign val = val_q;
  assign chg = val_d != val_q;
endmodule

// File: rtl/motion_controller.sv
// motion_controller: tick-divided 2-D cursor with saturating x/y coordinates
// Ports: clock, reset (sync, active-high), enable (run/freeze), left/right/up/down
//        (level requests sampled on tick), x_val/y_val (registered coordinates),
//        moved (one-clock pulse after a tick that changed a coordinate),
//        at_edge {up,down,left,right} (registered bound flags).
// Optional: define MOTION_ACCEL_EN for per-axis acceleration.
module motion_controller
  import motion_pkg::*;
#(
  parameter int W = 8,
  parameter int X_MIN = 0,
  parameter int X_MAX = 2**W-1,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 2**W-1,
  parameter int X_RESET = 0,
  parameter int Y_RESET = 0,
  parameter int TICK_DIV = 25_000_000,
  parameter int STEP = 1,
  parameter int HOLD_TICKS = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         left,
  input  logic         right,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] x_val,
  output logic [W-1:0] y_val,
  output logic         moved,
  output logic [3:0]   at_edge
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic moved_q, moved_d;
  logic [3:0] at_edge_q, at_edge_d;
  logic tick, x_chg, y_chg;
  assign tick = enable && cnt_q == '0;
  always_comb begin
    cnt_d = !enable ? cnt_q : tick ? CW'(TICK_DIV - 1) : cnt_q - 1'b1;
    moved_d = x_chg | y_chg;
    at_edge_d = '0;
    at_edge_d[EDGE_UP] = y_val == W'(Y_MAX);
    at_edge_d[EDGE_DOWN] = y_val == W'(Y_MIN);
    at_edge_d[EDGE_LEFT] = x_val == W'(X_MIN);
    at_edge_d[EDGE_RIGHT] = x_val == W'(X_MAX);
  end
  // at_edge tracks the registered coordinates, so it is not held by reset
  always_ff @(posedge clock) begin
    at_edge_q <= at_edge_d;
    if (reset) begin
      cnt_q <= CW'(TICK_DIV - 1);
      moved_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      moved_q <= moved_d;
    end
  end
  axis_stepper #(
    .W(W), .MIN(X_MIN), .MAX(X_MAX), .RST(X_RESET), .STEP(STEP), .HOLD_TICKS(HOLD_TICKS)
  ) u_x (
    .clock(clock), .reset(reset), .tick(tick), .inc(right), .dec(left), .val(x_val), .chg(x_chg)
  );
  axis_stepper #(
    .W(W), .MIN(Y_MIN), .MAX(Y_MAX), .RST(Y_RESET), .STEP(STEP), .HOLD_TICKS(HOLD_TICKS)
  ) u_y (
    .clock(clock), .reset(reset), .tick(tick), .inc(up), .dec(down), .val(y_val), .chg(y_chg)
  );
  assign moved = moved_q;
  assign at_edge = at_edge_q;
endmodule
